// File: rtl/apb_const_pkg.sv
// Shared definitions for the APB constant responder: address window, register
// indices, the constant words it serves, and the transfer FSM state type.
package apb_const_pkg;

  localparam logic [31:0] BASE_DEFAULT = 32'h7000_0000;

  localparam logic [3:0] IDX_PI_HI    = 4'd0;
  localparam logic [3:0] IDX_PI_LO    = 4'd1;
  localparam logic [3:0] IDX_E_HI     = 4'd2;
  localparam logic [3:0] IDX_E_LO     = 4'd3;
  localparam logic [3:0] IDX_SCRATCH  = 4'd4;
  localparam logic [3:0] IDX_WAIT_CFG = 4'd5;
  localparam logic [3:0] IDX_XFER_CNT = 4'd6;
  localparam logic [3:0] IDX_ERR_CNT  = 4'd7;

  // pi and e in 2.30 fixed point, followed by the next 32 fraction bits
  localparam logic [31:0] PI_HI_WORD = 32'hC90F_DAA2;
  localparam logic [31:0] PI_LO_WORD = 32'h2168_C234;
  localparam logic [31:0] E_HI_WORD  = 32'hADF8_5458;
  localparam logic [31:0] E_LO_WORD  = 32'hA2BB_4A9A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_ro(input logic [3:0] idx);
    logic ro;
    case (idx)
      IDX_PI_HI, IDX_PI_LO, IDX_E_HI, IDX_E_LO,
      IDX_XFER_CNT, IDX_ERR_CNT: ro = 1'b1;
      default:                   ro = 1'b0;
    endcase
    return ro;
  endfunction

  // Indices 8..15 are outside the register map.
  function automatic logic req_error(input logic base_ok, input logic [3:0] idx,
                                     input logic wr);
    return (!base_ok) || idx[3] || (wr && is_ro(idx));
  endfunction

endpackage

// File: rtl/apb_const_regfile.sv
// Register storage (SCRATCH, WAIT_CFG) and the read multiplexer over the whole
// 8-entry register map; counters are supplied by the parent.
module apb_const_regfile
  import apb_const_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  widx,
  input  logic [31:0] wdata,
  input  logic [3:0]  ridx,
  input  logic [31:0] xfer_cnt,
  input  logic [31:0] err_cnt,
  output logic [31:0] rdata,
  output logic [3:0]  wait_cfg
);

  logic [31:0] scratch_r;
  logic [3:0]  wait_cfg_r;

  // Writable register storage; only error-free writes reach here.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_r  <= 32'h0000_0000;
      wait_cfg_r <= 4'd0;
    end else if (we) begin
      case (widx)
        IDX_SCRATCH:  scratch_r  <= wdata;
        IDX_WAIT_CFG: wait_cfg_r <= wdata[3:0];
        default: begin
          scratch_r  <= scratch_r;
          wait_cfg_r <= wait_cfg_r;
        end
      endcase
    end else begin
      scratch_r  <= scratch_r;
      wait_cfg_r <= wait_cfg_r;
    end
  end

  // Read multiplexer over the register map.
  always_comb begin
    rdata = 32'h0000_0000;
    case (ridx)
      IDX_PI_HI:    rdata = PI_HI_WORD;
      IDX_PI_LO:    rdata = PI_LO_WORD;
      IDX_E_HI:     rdata = E_HI_WORD;
      IDX_E_LO:     rdata = E_LO_WORD;
      IDX_SCRATCH:  rdata = scratch_r;
      IDX_WAIT_CFG: rdata = {28'h000_0000, wait_cfg_r};
      IDX_XFER_CNT: rdata = xfer_cnt;
      IDX_ERR_CNT:  rdata = err_cnt;
      default:      rdata = 32'h0000_0000;
    endcase
  end

  assign wait_cfg = wait_cfg_r;

endmodule

// File: rtl/apb_const_responder.sv
// APB slave serving four constant words plus scratch/config/counter registers,
// with a programmable wait-state count before each response.
module apb_const_responder
  import apb_const_pkg::*;
#(
  parameter logic [31:0] P_BASE = BASE_DEFAULT
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  state_e      state_r;
  state_e      state_nx;
  logic        access_s;
  logic        start_s;
  logic        finish_s;
  logic        base_ok_s;
  logic        req_err_s;
  logic        we_s;

  logic [3:0]  cnt_r;
  logic [3:0]  idx_r;
  logic        wr_r;
  logic [31:0] wdata_r;
  logic        err_r;
  logic [31:0] prdata_r;
  logic        pready_r;
  logic        pslverr_r;
  logic [31:0] xfer_cnt_r;
  logic [31:0] err_cnt_r;

  logic [31:0] rdata_s;
  logic [3:0]  wait_cfg_s;

  assign access_s  = psel & penable;
  assign base_ok_s = (paddr[31:4] == P_BASE[31:4]);
  assign req_err_s = req_error(base_ok_s, paddr[3:0], pwrite);
  assign we_s      = finish_s & wr_r & ~err_r;

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; a dropped select during WAIT aborts without side effects.
  always_comb begin
    state_nx = state_r;
    start_s  = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (access_s) begin
          state_nx = S_WAIT;
          start_s  = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!access_s) begin
          state_nx = S_IDLE;
        end else if (cnt_r == 4'd0) begin
          state_nx = S_DONE;
          finish_s = 1'b1;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_DONE: begin
        if (access_s) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Request capture and wait-state countdown.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_r   <= 4'd0;
      idx_r   <= 4'd0;
      wr_r    <= 1'b0;
      wdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else if (start_s) begin
      cnt_r   <= wait_cfg_s;
      idx_r   <= paddr[3:0];
      wr_r    <= pwrite;
      wdata_r <= pwdata;
      err_r   <= req_err_s;
    end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r   <= cnt_r - 4'd1;
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  // Response outputs; prdata is captured once at completion and held in DONE.
  always_ff @(posedge pclk) begin
    if (preset) begin
      prdata_r  <= 32'h0000_0000;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
    end else begin
      pready_r  <= (state_nx == S_DONE);
      pslverr_r <= (state_nx == S_DONE) & err_r;
      if (finish_s) begin
        prdata_r <= err_r ? 32'h0000_0000 : rdata_s;
      end else if (state_nx == S_DONE) begin
        prdata_r <= prdata_r;
      end else begin
        prdata_r <= 32'h0000_0000;
      end
    end
  end

  // Transfer and error counters; the read mux sees the pre-increment value.
  always_ff @(posedge pclk) begin
    if (preset) begin
      xfer_cnt_r <= 32'h0000_0000;
      err_cnt_r  <= 32'h0000_0000;
    end else if (finish_s) begin
      xfer_cnt_r <= xfer_cnt_r + 32'd1;
      err_cnt_r  <= err_r ? (err_cnt_r + 32'd1) : err_cnt_r;
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
      err_cnt_r  <= err_cnt_r;
    end
  end

  apb_const_regfile u_regfile (
    .clk      (pclk),
    .rst      (preset),
    .we       (we_s),
    .widx     (idx_r),
    .wdata    (wdata_r),
    .ridx     (idx_r),
    .xfer_cnt (xfer_cnt_r),
    .err_cnt  (err_cnt_r),
    .rdata    (rdata_s),
    .wait_cfg (wait_cfg_s)
  );

  assign prdata  = prdata_r;
  assign pready  = pready_r;
  assign pslverr = pslverr_r;

endmodule
